// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // One FIFO entry: received byte plus the error tags captured for it.
  typedef struct packed {
    logic                   frame_err;
    logic                   parity_err;
    logic [UART_DATA_W-1:0] data;
  } uart_rx_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH storage array: synchronous write, asynchronous read.
// Storage is intentionally left unreset; validity is tracked by the pointers.
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port: one entry per enabled clock.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port is a plain mux so the head entry is visible without a read cycle.
  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: tags each byte with framing/parity errors seen since the
// previous byte, buffers entries in a show-ahead FIFO, and reports level,
// threshold, overrun and receive-idle timeout status.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   wr_valid,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   wr_frame_err,
  input  logic                   wr_parity_err,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   rd_frame_err,
  output logic                   rd_parity_err,
  output logic                   empty,
  output logic                   full,
  output logic [LVL_W-1:0]       level,
  input  logic [LVL_W-1:0]       thresh,
  output logic                   thresh_hit,
  output logic                   overrun,
  input  logic                   overrun_clr,
  input  logic [15:0]            timeout_cycles,
  output logic                   timeout
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = $bits(uart_rx_entry_t);

  // Idle counter step that holds at the programmed limit.
  function automatic logic [15:0] idle_sat_inc(input logic [15:0] cnt,
                                               input logic [15:0] limit);
    return (cnt < limit) ? cnt + 16'd1 : limit;
  endfunction

  logic [LVL_W-1:0]   r_wr_ptr;
  logic [LVL_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic               r_empty;
  logic               r_full;
  logic               r_overrun;
  logic               r_timeout;
  logic               r_pend_fe;
  logic               r_pend_pe;
  logic [15:0]        r_idle_cnt;

  logic               w_clear;
  logic               w_push_req;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [LVL_W-1:0]   w_wr_ptr_nxt;
  logic [LVL_W-1:0]   w_rd_ptr_nxt;
  logic [15:0]        w_idle_nxt;
  uart_rx_entry_t     w_wr_entry;
  uart_rx_entry_t     w_head;
  logic [ENTRY_W-1:0] w_head_raw;

  // Qualify push/pop and compute next pointers, idle count and the entry to store.
  always_comb begin
    w_clear      = flush || !enable;
    w_push_req   = wr_valid && !w_clear;
    w_pop        = rd_en && !r_empty && !w_clear;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    w_push       = w_push_req && (!r_full || w_pop);
    w_drop       = w_push_req && r_full && !w_pop;
    w_wr_ptr_nxt = '0;
    w_rd_ptr_nxt = '0;
    if (!w_clear) begin
      w_wr_ptr_nxt = r_wr_ptr + LVL_W'(w_push);
      w_rd_ptr_nxt = r_rd_ptr + LVL_W'(w_pop);
    end
    w_idle_nxt = '0;
    if (!(w_clear || w_push || w_pop || r_empty)) begin
      w_idle_nxt = idle_sat_inc(r_idle_cnt, timeout_cycles);
    end
    w_wr_entry.frame_err  = r_pend_fe | wr_frame_err;
    w_wr_entry.parity_err = r_pend_pe | wr_parity_err;
    w_wr_entry.data       = wr_data;
  end

  // Pointers and registered occupancy status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_level  <= w_wr_ptr_nxt - w_rd_ptr_nxt;
      r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
      r_full   <= (w_wr_ptr_nxt[LVL_W-1] != w_rd_ptr_nxt[LVL_W-1]) &&
                  (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
    end
  end

  // Pending error bits: collect pulses until the byte they belong to arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_fe <= 1'b0;
      r_pend_pe <= 1'b0;
    end else if (w_clear || wr_valid) begin
      r_pend_fe <= 1'b0;
      r_pend_pe <= 1'b0;
    end else begin
      r_pend_fe <= r_pend_fe | wr_frame_err;
      r_pend_pe <= r_pend_pe | wr_parity_err;
    end
  end

  // Sticky overrun; software clear wins over a drop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end
  end

  // Idle counter and timeout flag, both derived from the next counter value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_idle_cnt <= w_idle_nxt;
      r_timeout  <= (timeout_cycles != '0) && (w_idle_nxt == timeout_cycles);
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .AW    (AW)
  ) u_mem (
    .i_clk     (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (w_wr_entry),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_head_raw)
  );

  // Head entry is forced to zero while empty so unwritten storage never leaks out.
  always_comb begin
    w_head        = uart_rx_entry_t'(w_head_raw);
    rd_data       = r_empty ? '0 : w_head.data;
    rd_frame_err  = !r_empty && w_head.frame_err;
    rd_parity_err = !r_empty && w_head.parity_err;
    empty         = r_empty;
    full          = r_full;
    level         = r_level;
    overrun       = r_overrun;
    timeout       = r_timeout;
    thresh_hit    = (thresh != '0) && (r_level >= thresh);
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int LVL_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             flush;
  logic             wr_valid;
  logic [7:0]       wr_data;
  logic             wr_frame_err;
  logic             wr_parity_err;
  logic             rd_en;
  logic [7:0]       rd_data;
  logic             rd_frame_err;
  logic             rd_parity_err;
  logic             empty;
  logic             full;
  logic [LVL_W-1:0] level;
  logic [LVL_W-1:0] thresh;
  logic             thresh_hit;
  logic             overrun;
  logic             overrun_clr;
  logic [15:0]      timeout_cycles;
  logic             timeout;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .flush          (flush),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_frame_err   (wr_frame_err),
    .wr_parity_err  (wr_parity_err),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_frame_err   (rd_frame_err),
    .rd_parity_err  (rd_parity_err),
    .empty          (empty),
    .full           (full),
    .level          (level),
    .thresh         (thresh),
    .thresh_hit     (thresh_hit),
    .overrun        (overrun),
    .overrun_clr    (overrun_clr),
    .timeout_cycles (timeout_cycles),
    .timeout        (timeout)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: entry queue, pending tags, sticky overrun,
  // and the cycle index of the last push/pop/flush for the timeout rule.
  logic [9:0] mq[$];
  bit         m_pfe;
  bit         m_ppe;
  bit         m_ov;
  int         cyc      = 0;
  int         last_evt = 0;

  typedef struct {
    logic             wv;
    logic [7:0]       d;
    logic             fe;
    logic             pe;
    logic             re;
    logic [LVL_W-1:0] lvl;
    logic             emp;
    logic [9:0]       head;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pfe    = 1'b0;
    m_ppe    = 1'b0;
    m_ov     = 1'b0;
    last_evt = cyc;
  endtask

  task automatic check_model();
    int         sz;
    logic       exp_to;
    logic       exp_th;
    logic [9:0] exp_st;
    logic [9:0] got_st;
    sz     = mq.size();
    exp_to = (sz != 0) && (timeout_cycles != 16'd0) &&
             ((cyc - last_evt) >= (int'(timeout_cycles) + 1));
    exp_th = (thresh != '0) && (sz >= int'(thresh));
    exp_st = {sz == 0, sz == DEPTH, LVL_W'(sz), m_ov, exp_to, exp_th};
    got_st = {empty, full, level, overrun, timeout, thresh_hit};
    chk($sformatf("model_status@%0d", cyc), 32'(got_st), 32'(exp_st));
    if (sz != 0) begin
      chk($sformatf("model_head@%0d", cyc),
          32'({rd_frame_err, rd_parity_err, rd_data}), 32'(mq[0]));
    end
  endtask

  // Advance one clock: update the model from the current inputs, then compare.
  task automatic step();
    bit         push_req;
    bit         pop;
    bit         acc;
    bit         drop;
    logic [9:0] ent;
    push_req = wr_valid && enable && !flush;
    pop      = rd_en && (mq.size() != 0);
    ent      = {m_pfe | wr_frame_err, m_ppe | wr_parity_err, wr_data};
    drop     = 1'b0;
    if (!enable || flush) begin
      mq.delete();
      m_pfe    = 1'b0;
      m_ppe    = 1'b0;
      last_evt = cyc;
    end else begin
      acc  = push_req && ((mq.size() < DEPTH) || pop);
      drop = push_req && !acc;
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(ent);
      if (acc || pop) last_evt = cyc;
      if (wr_valid) begin
        m_pfe = 1'b0;
        m_ppe = 1'b0;
      end else begin
        m_pfe = m_pfe | wr_frame_err;
        m_ppe = m_ppe | wr_parity_err;
      end
    end
    if (overrun_clr) m_ov = 1'b0;
    else if (drop)   m_ov = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    check_model();
  endtask

  task automatic drive(input logic wv, input logic [7:0] d, input logic fe,
                       input logic pe, input logic re);
    wr_valid      = wv;
    wr_data       = d;
    wr_frame_err  = fe;
    wr_parity_err = pe;
    rd_en         = re;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  task automatic rand_drive(input int wp, input int rp);
    wr_valid      = ($urandom_range(99) < wp);
    wr_data       = 8'($urandom);
    wr_frame_err  = ($urandom_range(99) < 10);
    wr_parity_err = ($urandom_range(99) < 10);
    rd_en         = ($urandom_range(99) < rp);
    flush         = ($urandom_range(199) == 0);
    enable        = ($urandom_range(99) != 0);
    overrun_clr   = ($urandom_range(99) < 5);
    thresh        = LVL_W'($urandom_range(16));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_k;
    int wps[4];
    int rps[4];
    int tcs[4];

    rst = 1'b1; enable = 1'b1; flush = 1'b0; overrun_clr = 1'b0;
    thresh = 5'd4; timeout_cycles = 16'd20;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty",      32'(empty),         32'd1);
    chk("rst_full",       32'(full),          32'd0);
    chk("rst_level",      32'(level),         32'd0);
    chk("rst_thresh_hit", 32'(thresh_hit),    32'd0);
    chk("rst_overrun",    32'(overrun),       32'd0);
    chk("rst_timeout",    32'(timeout),       32'd0);
    chk("rst_rd_data",    32'(rd_data),       32'd0);
    chk("rst_tags",       32'({rd_frame_err, rd_parity_err}), 32'd0);
    rst = 1'b0;
    model_reset();

    // Vector table: {wv, data, fe, pe, rd_en} -> {level, empty, head}.
    tbl[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 10'h041};
    tbl[1]  = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 10'h041};
    tbl[2]  = '{1'b1, 8'h43, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0, 10'h041};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 10'h042};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 10'h043};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 10'h000};
    tbl[6]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 10'h200};
    tbl[7]  = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 10'h177};
    tbl[8]  = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 10'h35A};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 10'h000};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 10'h000};
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].wv, tbl[i].d, tbl[i].fe, tbl[i].pe, tbl[i].re);
      step();
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
      if (tbl[i].emp)
        chk($sformatf("vec%0d_tags", i), 32'({rd_frame_err, rd_parity_err}), 32'd0);
      else
        chk($sformatf("vec%0d_head", i),
            32'({rd_frame_err, rd_parity_err, rd_data}), 32'(tbl[i].head));
    end

    // Error pulse ten cycles ahead of its byte, then a same-cycle framing error.
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0); step();
    for (int i = 0; i < 10; i++) idle();
    drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0); step();
    chk("early_parity_head", 32'({rd_frame_err, rd_parity_err, rd_data}), 32'h15A);
    drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); step();
    chk("same_cycle_frame_head", 32'({rd_frame_err, rd_parity_err, rd_data}), 32'h200);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); step();
    chk("err_drained_empty", 32'(empty), 32'd1);

    // Fill past full with threshold 4, clear overrun, push+pop at full, drain.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0); step();
      if (i == 2) chk("thresh_before_4th", 32'(thresh_hit), 32'd0);
      if (i == 3) chk("thresh_at_4th", 32'(thresh_hit), 32'd1);
    end
    chk("ovr_full",    32'(full),    32'd1);
    chk("ovr_level",   32'(level),   32'd16);
    chk("ovr_overrun", 32'(overrun), 32'd1);
    chk("ovr_head",    32'(rd_data), 32'h00);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);
    drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1); step();
    chk("full_pushpop_level",   32'(level),   32'd16);
    chk("full_pushpop_overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), 32'(rd_data), (i < 15) ? 32'(i + 1) : 32'hAA);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); step();
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Timeout: 20-cycle limit must fire 21 cycles after the last push.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0); step();
    end
    chk("timeout_low_after_push", 32'(timeout), 32'd0);
    first_k = -1;
    for (int k = 1; k <= 30; k++) begin
      idle();
      if (timeout && first_k < 0) first_k = k;
    end
    chk("timeout_delay", 32'(first_k), 32'd20);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); step();
    chk("timeout_cleared_by_pop", 32'(timeout), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); step();

    // Flush with 5 entries, overrun set and a pending parity tag.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0); step();
    end
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); step();
    end
    chk("pre_flush_level",   32'(level),   32'd5);
    chk("pre_flush_overrun", 32'(overrun), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0); step();
    drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0); flush = 1'b1; step(); flush = 1'b0;
    chk("flush_empty",   32'(empty),   32'd1);
    chk("flush_level",   32'(level),   32'd0);
    chk("flush_overrun", 32'(overrun), 32'd1);
    drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b0); step();
    chk("post_flush_head", 32'({rd_frame_err, rd_parity_err, rd_data}), 32'h033);
    enable = 1'b0;
    drive(1'b1, 8'h44, 1'b0, 1'b0, 1'b0); step();
    chk("disable_empty_1", 32'(empty), 32'd1);
    drive(1'b1, 8'h45, 1'b0, 1'b0, 1'b0); step();
    chk("disable_empty_2", 32'(empty), 32'd1);
    enable = 1'b1;

    // Randomized traffic in phases with different fill biases and limits.
    wps = '{70, 20, 50, 60};
    rps = '{20, 70, 50, 45};
    tcs = '{5, 0, 12, 3};
    for (int p = 0; p < 4; p++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      timeout_cycles = 16'(tcs[p]);
      flush = 1'b1; step(); flush = 1'b0;
      for (int n = 0; n < 800; n++) begin
        rand_drive(wps[p], rps[p]);
        step();
      end
    end
    flush = 1'b0; enable = 1'b1; overrun_clr = 1'b0; thresh = 5'd4;

    // Asynchronous reset in the middle of a cycle clears everything at once.
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); flush = 1'b1; step(); flush = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0); step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_overrun", 32'(overrun), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_empty",   32'(empty),   32'd1);
    chk("midrst_full",    32'(full),    32'd0);
    chk("midrst_level",   32'(level),   32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    chk("midrst_timeout", 32'(timeout), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    drive(1'b1, 8'h99, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
